pc_ctrl: RTL and testbench

Next-PC sequencer for the 5-stage RISC-V pipeline. It owns the fetch program counter and arbitrates between sequential advance, ID-stage jumps, EX-stage branch/JALR redirects and MEM-stage traps. It drives the instruction-memory request handshake and holds a pending redirect across memory wait states. It also generates the IF/ID and ID/EX flush strobes consumed by the pipeline registers.

---
 rtl/pc_ctrl_if.sv | 37 +++
 rtl/pc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: bundles the fetch-sequencer control, redirect and
// instruction-memory handshake signals of pc_ctrl.
//   slave  : pc_ctrl side (redirects/handshake in, PC/strobes out)
//   master : pipeline/testbench side (the reverse directions)
interface pc_ctrl_if;
    logic        stall;
    logic        id_jump_en;
    logic [31:0] id_jump_pc;
    logic        ex_redirect_en;
    logic [31:0] ex_redirect_pc;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic        if_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;

    modport slave (
        input  stall, id_jump_en, id_jump_pc, ex_redirect_en, ex_redirect_pc,
               trap_en, trap_pc, halt_req, resume, imem_ready,
        output imem_req, imem_addr, pc_out, if_valid, flush_ifid, flush_idex,
               misalign_err
    );

    modport master (
        output stall, id_jump_en, id_jump_pc, ex_redirect_en, ex_redirect_pc,
               trap_en, trap_pc, halt_req, resume, imem_ready,
        input  imem_req, imem_addr, pc_out, if_valid, flush_ifid, flush_idex,
               misalign_err
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC sequencer for the 5-stage pipeline. Owns the fetch PC,
// arbitrates trap > EX redirect > ID jump > sequential, drives the
// instruction-memory request and parks redirects that arrive while a fetch
// is waiting on memory. Also produces the IF/ID and ID/EX flush strobes.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - pc_ctrl_if.slave: stall, redirects, halt/resume, imem handshake,
//           pc_out/imem_addr, if_valid, flush strobes, misalign_err
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | requesting pc_out (unless stalled); redirects load immediately
// WAIT  | request outstanding, memory not ready; redirects are parked
// HALT  | fetch stopped; resume or trap restarts it
module pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    pc_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_HALT} state_t;

    // Redirect priority classes; numeric order is the priority order.
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_ID   = 2'd1;
    localparam logic [1:0] CLS_EX   = 2'd2;
    localparam logic [1:0] CLS_TRAP = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_cls_q, pend_cls_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        misalign_err_q, misalign_err_d;

    logic        ex_ok, id_ok, bad_tgt;
    logic [1:0]  rd_cls;
    logic [31:0] rd_pc;
    logic        rd_v;
    logic        req;
    logic [31:0] pc_inc;
    logic        pend_e;
    logic [1:0]  pend_cls_e;
    logic [31:0] pend_pc_e;

    // Misaligned EX/ID targets are treated as absent; trap_pc is trusted.
    always_comb begin
        ex_ok   = bus.ex_redirect_en && (bus.ex_redirect_pc[1:0] == 2'b00);
        id_ok   = bus.id_jump_en && (bus.id_jump_pc[1:0] == 2'b00);
        bad_tgt = (bus.ex_redirect_en && (bus.ex_redirect_pc[1:0] != 2'b00)) ||
                  (bus.id_jump_en && (bus.id_jump_pc[1:0] != 2'b00));
        rd_cls  = CLS_NONE;
        rd_pc   = '0;
        if (bus.trap_en) begin
            rd_cls = CLS_TRAP;
            rd_pc  = bus.trap_pc;
        end else if (ex_ok) begin
            rd_cls = CLS_EX;
            rd_pc  = bus.ex_redirect_pc;
        end else if (id_ok) begin
            rd_cls = CLS_ID;
            rd_pc  = bus.id_jump_pc;
        end
        rd_v = (rd_cls != CLS_NONE);
    end

    assign bus.flush_ifid = rd_v;
    assign bus.flush_idex = bus.trap_en || ex_ok;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        if_valid_d     = 1'b0;
        pend_d         = pend_q;
        pend_cls_d     = pend_cls_q;
        pend_pc_d      = pend_pc_q;
        misalign_err_d = bad_tgt;
        req            = 1'b0;
        pc_inc         = pc_q + 32'd4;

        // Pending view including a redirect arriving this cycle: equal or
        // higher priority replaces what is parked, lower priority is dropped.
        pend_e     = pend_q;
        pend_cls_e = pend_cls_q;
        pend_pc_e  = pend_pc_q;
        if (rd_v && (!pend_q || (rd_cls >= pend_cls_q))) begin
            pend_e     = 1'b1;
            pend_cls_e = rd_cls;
            pend_pc_e  = rd_pc;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                req = !bus.stall;
                if (rd_v) begin
                    // The in-flight request is abandoned for the new target.
                    pc_d = rd_pc;
                    if (bus.halt_req && (!req || bus.imem_ready))
                        state_d = S_HALT;
                end else if (req && bus.imem_ready) begin
                    pc_d       = pc_inc;
                    if_valid_d = 1'b1;
                    if (bus.halt_req)
                        state_d = S_HALT;
                end else if (req) begin
                    state_d = S_WAIT;
                end else if (bus.halt_req) begin
                    state_d = S_HALT;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.imem_ready) begin
                    pc_d       = pend_e ? pend_pc_e : pc_inc;
                    if_valid_d = !pend_e;
                    pend_d     = 1'b0;
                    pend_cls_d = CLS_NONE;
                    pend_pc_d  = '0;
                    state_d    = bus.halt_req ? S_HALT : S_FETCH;
                end else begin
                    pend_d     = pend_e;
                    pend_cls_d = pend_cls_e;
                    pend_pc_d  = pend_pc_e;
                end
            end
            S_HALT: begin
                if (bus.trap_en) begin
                    pc_d    = bus.trap_pc;
                    state_d = S_FETCH;
                end else if (bus.resume) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_VECTOR;
            if_valid_q     <= 1'b0;
            pend_q         <= 1'b0;
            pend_cls_q     <= CLS_NONE;
            pend_pc_q      <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            if_valid_q     <= if_valid_d;
            pend_q         <= pend_d;
            pend_cls_q     <= pend_cls_d;
            pend_pc_q      <= pend_pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc_q;
    assign bus.pc_out       = pc_q;
    assign bus.if_valid     = if_valid_q;
    assign bus.misalign_err = misalign_err_q;
endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_ctrl_if bus ();
    pc_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        stall;
        logic        id_en;
        logic [31:0] id_pc;
        logic        ex_en;
        logic [31:0] ex_pc;
        logic        trap_en;
        logic [31:0] trap_pc;
        logic        halt;
        logic        resume;
        logic        ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] pc;
        logic        valid;
        logic        merr;
        logic        req;
        logic        fi;
        logic        fx;
    } vec_t;

    typedef struct {
        int          rank;
        logic [31:0] tgt;
    } pend_t;

    localparam int PH_BOOT = 0, PH_FETCH = 1, PH_WAIT = 2, PH_HALT = 3;

    int n_pass = 0;
    int n_total = 0;

    int          m_phase;
    logic [31:0] m_pc;
    logic        m_valid, m_merr;
    pend_t       m_pend[$];

    vec_t tbl[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.stall = 0; s.id_en = 0; s.id_pc = 0; s.ex_en = 0; s.ex_pc = 0;
        s.trap_en = 0; s.trap_pc = 0; s.halt = 0; s.resume = 0; s.ready = 1;
        return s;
    endfunction

    function automatic vec_t row(logic [31:0] pc, logic v, logic m, logic rq, logic fi, logic fx);
        vec_t r;
        r.s = idle();
        r.pc = pc; r.valid = v; r.merr = m; r.req = rq; r.fi = fi; r.fx = fx;
        return r;
    endfunction

    function automatic bit aligned(logic [31:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        return lo == 2'b00;
    endfunction

    // Highest-priority usable redirect: rank 3 trap, 2 EX, 1 ID, 0 none.
    task automatic best_redirect(input stim_t s, output int rank, output logic [31:0] tgt);
        int          ranks[3];
        logic [31:0] tgts[3];
        bit          ok[3];
        ranks = '{3, 2, 1};
        tgts  = '{s.trap_pc, s.ex_pc, s.id_pc};
        ok    = '{s.trap_en, s.ex_en && aligned(s.ex_pc), s.id_en && aligned(s.id_pc)};
        rank = 0;
        tgt  = 0;
        for (int i = 0; i < 3; i++)
            if (ok[i] && ranks[i] > rank) begin
                rank = ranks[i];
                tgt  = tgts[i];
            end
    endtask

    task automatic model_reset();
        m_phase = PH_BOOT;
        m_pc    = 32'h0;
        m_valid = 0;
        m_merr  = 0;
        m_pend.delete();
    endtask

    task automatic run_cycle(input stim_t s, input bit rst, input bit has_exp, input vec_t e);
        int          rank;
        logic [31:0] tgt;
        bit          e_req, rejected, accepted;
        reset              = rst;
        bus.stall          = s.stall;
        bus.id_jump_en     = s.id_en;
        bus.id_jump_pc     = s.id_pc;
        bus.ex_redirect_en = s.ex_en;
        bus.ex_redirect_pc = s.ex_pc;
        bus.trap_en        = s.trap_en;
        bus.trap_pc        = s.trap_pc;
        bus.halt_req       = s.halt;
        bus.resume         = s.resume;
        bus.imem_ready     = s.ready;
        @(negedge clk);

        best_redirect(s, rank, tgt);
        e_req = (m_phase == PH_FETCH) ? !s.stall : (m_phase == PH_WAIT);
        chk("pc_out", bus.pc_out, m_pc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
        chk("misalign_err", 32'(bus.misalign_err), 32'(m_merr));
        chk("flush_ifid", 32'(bus.flush_ifid), 32'(rank > 0));
        chk("flush_idex", 32'(bus.flush_idex), 32'(rank >= 2));
        if (has_exp) begin
            chk("tbl_pc", bus.pc_out, e.pc);
            chk("tbl_valid", 32'(bus.if_valid), 32'(e.valid));
            chk("tbl_merr", 32'(bus.misalign_err), 32'(e.merr));
            chk("tbl_req", 32'(bus.imem_req), 32'(e.req));
            chk("tbl_flush_ifid", 32'(bus.flush_ifid), 32'(e.fi));
            chk("tbl_flush_idex", 32'(bus.flush_idex), 32'(e.fx));
        end

        rejected = (s.ex_en && !aligned(s.ex_pc)) || (s.id_en && !aligned(s.id_pc));
        if (rst) begin
            model_reset();
        end else begin
            m_merr = rejected;
            case (m_phase)
                PH_BOOT: begin
                    m_valid = 0;
                    m_phase = PH_FETCH;
                end
                PH_FETCH: begin
                    accepted = e_req && s.ready;
                    m_valid = 0;
                    if (rank > 0) begin
                        m_pc = tgt;
                        if (s.halt && (!e_req || s.ready)) m_phase = PH_HALT;
                    end else if (accepted) begin
                        m_pc = m_pc + 32'd4;
                        m_valid = 1;
                        if (s.halt) m_phase = PH_HALT;
                    end else if (e_req) begin
                        m_phase = PH_WAIT;
                    end else if (s.halt) begin
                        m_phase = PH_HALT;
                    end
                end
                PH_WAIT: begin
                    if (rank > 0 && (m_pend.size() == 0 || rank >= m_pend[0].rank)) begin
                        m_pend.delete();
                        m_pend.push_back('{rank, tgt});
                    end
                    m_valid = 0;
                    if (s.ready) begin
                        if (m_pend.size() != 0) begin
                            m_pc = m_pend[0].tgt;
                            m_pend.delete();
                        end else begin
                            m_pc = m_pc + 32'd4;
                            m_valid = 1;
                        end
                        m_phase = s.halt ? PH_HALT : PH_FETCH;
                    end
                end
                default: begin
                    m_valid = 0;
                    if (s.trap_en) begin
                        m_pc = s.trap_pc;
                        m_phase = PH_FETCH;
                    end else if (s.resume) begin
                        m_phase = PH_FETCH;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = $urandom;
        t[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    initial begin
        vec_t  dummy;
        stim_t s;
        bit    r;
        dummy = row(0, 0, 0, 0, 0, 0);

        tbl[0]  = row(32'h0000_0000, 0, 0, 0, 0, 0);
        tbl[1]  = row(32'h0000_0000, 0, 0, 1, 0, 0);
        tbl[2]  = row(32'h0000_0004, 1, 0, 1, 0, 0);
        tbl[3]  = row(32'h0000_0008, 1, 0, 1, 0, 0);
        tbl[4]  = row(32'h0000_000C, 1, 0, 1, 0, 0);
        tbl[5]  = row(32'h0000_0010, 1, 0, 1, 1, 1);
        tbl[5].s.ex_en = 1; tbl[5].s.ex_pc = 32'h200;
        tbl[6]  = row(32'h0000_0200, 0, 0, 1, 0, 0);
        tbl[7]  = row(32'h0000_0204, 1, 0, 1, 0, 0);
        tbl[7].s.ex_en = 1; tbl[7].s.ex_pc = 32'h102;
        tbl[8]  = row(32'h0000_0208, 1, 1, 1, 0, 0);
        tbl[9]  = row(32'h0000_020C, 1, 0, 1, 1, 0);
        tbl[9].s.id_en = 1; tbl[9].s.id_pc = 32'h40;
        tbl[10] = row(32'h0000_0040, 0, 0, 1, 0, 0);
        tbl[10].s.ready = 0;
        tbl[11] = row(32'h0000_0040, 0, 0, 1, 1, 0);
        tbl[11].s.ready = 0; tbl[11].s.id_en = 1; tbl[11].s.id_pc = 32'h80;
        tbl[12] = row(32'h0000_0040, 0, 0, 1, 1, 1);
        tbl[12].s.ready = 0; tbl[12].s.ex_en = 1; tbl[12].s.ex_pc = 32'h100;
        tbl[13] = row(32'h0000_0040, 0, 0, 1, 0, 0);
        tbl[14] = row(32'h0000_0100, 0, 0, 1, 1, 1);
        tbl[14].s.trap_en = 1; tbl[14].s.trap_pc = 32'h1C0;
        tbl[14].s.ex_en = 1;   tbl[14].s.ex_pc = 32'h300;
        tbl[14].s.id_en = 1;   tbl[14].s.id_pc = 32'h400;
        tbl[15] = row(32'h0000_01C0, 0, 0, 1, 1, 0);
        tbl[15].s.id_en = 1; tbl[15].s.id_pc = 32'h20;
        tbl[16] = row(32'h0000_0020, 0, 0, 0, 0, 0);
        tbl[16].s.stall = 1;
        tbl[17] = row(32'h0000_0020, 0, 0, 0, 1, 1);
        tbl[17].s.stall = 1; tbl[17].s.ex_en = 1; tbl[17].s.ex_pc = 32'h60;
        tbl[18] = row(32'h0000_0060, 0, 0, 1, 0, 0);
        tbl[18].s.halt = 1;
        tbl[19] = row(32'h0000_0064, 1, 0, 0, 0, 0);
        tbl[19].s.halt = 1;
        tbl[20] = row(32'h0000_0064, 0, 0, 0, 0, 0);
        tbl[21] = row(32'h0000_0064, 0, 0, 0, 0, 0);
        tbl[21].s.resume = 1;
        tbl[22] = row(32'h0000_0064, 0, 0, 1, 0, 0);
        tbl[23] = row(32'h0000_0068, 1, 0, 1, 1, 0);
        tbl[23].s.id_en = 1; tbl[23].s.id_pc = 32'hFFFF_FFFC;
        tbl[24] = row(32'hFFFF_FFFC, 0, 0, 1, 0, 0);
        tbl[25] = row(32'h0000_0000, 1, 0, 1, 0, 0);

        // Unchecked power-up reset: outputs are unknown before the first edge.
        reset = 1'b1;
        s = idle();
        bus.stall = 0; bus.id_jump_en = 0; bus.id_jump_pc = 0;
        bus.ex_redirect_en = 0; bus.ex_redirect_pc = 0; bus.trap_en = 0;
        bus.trap_pc = 0; bus.halt_req = 0; bus.resume = 0; bus.imem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        foreach (tbl[i])
            run_cycle(tbl[i].s, 1'b0, 1'b1, tbl[i]);

        // Reset in mid-flight, including from WAIT with a parked redirect.
        s = idle(); s.ready = 0;
        run_cycle(s, 1'b0, 1'b0, dummy);
        s.id_en = 1; s.id_pc = 32'h800;
        run_cycle(s, 1'b0, 1'b0, dummy);
        run_cycle(idle(), 1'b1, 1'b0, dummy);
        run_cycle(idle(), 1'b0, 1'b1, row(32'h0, 0, 0, 0, 0, 0));
        run_cycle(idle(), 1'b0, 1'b1, row(32'h0, 0, 0, 1, 0, 0));
        run_cycle(idle(), 1'b0, 1'b1, row(32'h4, 1, 0, 1, 0, 0));

        for (int c = 0; c < 3000; c++) begin
            s.stall   = ($urandom_range(0, 5) == 0);
            s.id_en   = ($urandom_range(0, 4) == 0);
            s.id_pc   = rnd_tgt();
            s.ex_en   = ($urandom_range(0, 5) == 0);
            s.ex_pc   = rnd_tgt();
            s.trap_en = ($urandom_range(0, 19) == 0);
            s.trap_pc = $urandom;
            s.halt    = ($urandom_range(0, 24) == 0);
            s.resume  = ($urandom_range(0, 7) == 0);
            s.ready   = ($urandom_range(0, 2) != 0);
            r         = ($urandom_range(0, 249) == 0);
            run_cycle(s, r, 1'b0, dummy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
